// File: rtl/kyber_ct_pkg.sv
// rtl/kyber_ct_pkg.sv - shared constants and state encoding for the ciphertext assembler
//
// Purpose: default geometry of a Kyber512 ciphertext as seen by the assembler.
// A ciphertext is 24 chunks of 256 bits (768 bytes). Each chunk holds 8 host
// words of 32 bits, which gives 192 words in total.
// Ports: none (package).

package kyber_ct_pkg;

  localparam int CT_WORD_WIDTH  = 32;
  localparam int CT_CHUNK_WIDTH = 256;
  localparam int CT_NUM_CHUNKS  = 24;
  localparam int CT_WPC         = CT_CHUNK_WIDTH / CT_WORD_WIDTH;
  localparam int CT_NUM_WORDS   = CT_NUM_CHUNKS * CT_WPC;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } ct_state_e;

endpackage

// File: rtl/ct_assembler_if.sv
// rtl/ct_assembler_if.sv - host write port and chunk stream bundle of the assembler
//
// Purpose: groups the host-side word writes and commands with the chunk stream
// going to the decapsulation core.
// Ports (signals):
//   i_we, i_addr, i_data_in   host word write
//   i_go, i_clear             host commands
//   o_inready, o_count,
//   o_full, o_err, o_done     status back to the host
//   o_chunk_data, o_chunk_idx,
//   o_chunk_valid,
//   i_chunk_ready             chunk stream with valid/ready handshake
// Modports: slave = assembler side, master = host/consumer side.

interface ct_assembler_if
  import kyber_ct_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WORD_WIDTH  = CT_WORD_WIDTH,
  parameter int CHUNK_WIDTH = CT_CHUNK_WIDTH
) ();

  logic                   i_we;
  logic [ADDR_WIDTH-1:0]  i_addr;
  logic [WORD_WIDTH-1:0]  i_data_in;
  logic                   i_go;
  logic                   i_clear;
  logic                   o_inready;
  logic [ADDR_WIDTH-1:0]  o_count;
  logic                   o_full;
  logic [CHUNK_WIDTH-1:0] o_chunk_data;
  logic [4:0]             o_chunk_idx;
  logic                   o_chunk_valid;
  logic                   i_chunk_ready;
  logic                   o_done;
  logic                   o_err;

  modport slave (
    input  i_we, i_addr, i_data_in, i_go, i_clear, i_chunk_ready,
    output o_inready, o_count, o_full, o_chunk_data, o_chunk_idx,
           o_chunk_valid, o_done, o_err
  );

  modport master (
    output i_we, i_addr, i_data_in, i_go, i_clear, i_chunk_ready,
    input  o_inready, o_count, o_full, o_chunk_data, o_chunk_idx,
           o_chunk_valid, o_done, o_err
  );

endinterface

// File: rtl/ct_word_buffer.sv
// rtl/ct_word_buffer.sv - ciphertext word store with written-mask and chunk read port
//
// Purpose: holds NUM_WORDS host words, remembers which addresses have been
// written since the last mask clear, and presents one whole chunk
// combinationally. Word 0 of a chunk sits in the most significant field.
// Ports:
//   i_clk, i_resetn   clock, synchronous active-low reset (clears mask only)
//   i_we, i_addr,
//   i_data            word write; out-of-range addresses are ignored
//   i_mask_clr        forget all written marks
//   o_written         mask bit of i_addr (0 for out-of-range addresses)
//   i_rd_idx          chunk index for the read port
//   o_rd_chunk        chunk i_rd_idx, word 0 in the top field

module ct_word_buffer
  import kyber_ct_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WORD_WIDTH  = CT_WORD_WIDTH,
  parameter int CHUNK_WIDTH = CT_CHUNK_WIDTH,
  parameter int NUM_CHUNKS  = CT_NUM_CHUNKS
) (
  input  logic                   i_clk,
  input  logic                   i_resetn,
  input  logic                   i_we,
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [WORD_WIDTH-1:0]  i_data,
  input  logic                   i_mask_clr,
  output logic                   o_written,
  input  logic [4:0]             i_rd_idx,
  output logic [CHUNK_WIDTH-1:0] o_rd_chunk
);

  localparam int WPC       = CHUNK_WIDTH / WORD_WIDTH;
  localparam int NUM_WORDS = NUM_CHUNKS * WPC;
  localparam int IW        = $clog2(NUM_WORDS);

  logic [WORD_WIDTH-1:0] mem [NUM_WORDS];
  logic [NUM_WORDS-1:0]  mask;

  logic          in_range;
  logic [IW-1:0] waddr;

  assign in_range  = i_addr < ADDR_WIDTH'(NUM_WORDS);
  assign waddr     = i_addr[IW-1:0];
  assign o_written = in_range && mask[waddr];

  // Storage is deliberately not reset; the mask alone decides validity.
  always_ff @(posedge i_clk) begin
    if (i_we && in_range) begin
      mem[waddr] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn || i_mask_clr) begin
      mask <= '0;
    end else if (i_we && in_range) begin
      mask[waddr] <= 1'b1;
    end
  end

  always_comb begin
    o_rd_chunk = '0;
    for (int k = 0; k < WPC; k++) begin
      o_rd_chunk[CHUNK_WIDTH-1-WORD_WIDTH*k -: WORD_WIDTH] =
        mem[IW'(int'(i_rd_idx) * WPC + k)];
    end
  end

endmodule

// File: rtl/ct_assembler.sv
// rtl/ct_assembler.sv - collects ciphertext words by address and streams them as chunks
//
// Purpose: in FILL the host writes 32-bit words by address; once every word
// has been written, i_go switches to SEND and the ciphertext leaves as
// NUM_CHUNKS chunks of CHUNK_WIDTH bits over a valid/ready handshake, chunk 0
// first. o_done pulses after the last chunk is accepted, and the block then
// returns to FILL with an empty mask.
// Ports:
//   i_clk, i_resetn   clock, synchronous active-low reset
//   bus (slave)       host writes/commands, status and chunk stream

module ct_assembler
  import kyber_ct_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WORD_WIDTH  = CT_WORD_WIDTH,
  parameter int CHUNK_WIDTH = CT_CHUNK_WIDTH,
  parameter int NUM_CHUNKS  = CT_NUM_CHUNKS
) (
  input logic           i_clk,
  input logic           i_resetn,
  ct_assembler_if.slave bus
);

  localparam int                    WPC         = CHUNK_WIDTH / WORD_WIDTH;
  localparam int                    NUM_WORDS   = NUM_CHUNKS * WPC;
  localparam logic [ADDR_WIDTH-1:0] NUM_WORDS_A = ADDR_WIDTH'(NUM_WORDS);
  localparam logic [4:0]            LAST_IDX    = 5'(NUM_CHUNKS - 1);

  ct_state_e              state;
  logic                   inready_q;
  logic [ADDR_WIDTH-1:0]  count_q;
  logic                   err_q;
  logic [CHUNK_WIDTH-1:0] chunk_q;
  logic [4:0]             idx_q;
  logic                   valid_q;
  logic                   done_q;

  logic                   full;
  logic                   addr_ok;
  logic                   accept;
  logic                   last_accept;
  logic                   buf_we;
  logic                   mask_clr;
  logic                   written;
  logic [4:0]             rd_idx;
  logic [CHUNK_WIDTH-1:0] rd_chunk;

  assign full        = (count_q == NUM_WORDS_A);
  assign addr_ok     = (bus.i_addr < NUM_WORDS_A);
  assign accept      = valid_q && bus.i_chunk_ready;
  assign last_accept = (state == SEND) && accept && (idx_q == LAST_IDX);

  // Writes only land in FILL; a simultaneous clear discards them.
  assign buf_we   = (state == FILL) && bus.i_we && addr_ok && !bus.i_clear;
  assign mask_clr = bus.i_clear || last_accept;

  // The read port looks one chunk ahead so the next chunk is ready to load on
  // the accepting edge. In FILL it points at chunk 0 for the i_go load. At the
  // last chunk it stays put to avoid reading past the array.
  always_comb begin
    rd_idx = 5'd0;
    if (state == SEND) begin
      rd_idx = (idx_q == LAST_IDX) ? idx_q : idx_q + 5'd1;
    end
  end

  ct_word_buffer #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .WORD_WIDTH  (WORD_WIDTH),
    .CHUNK_WIDTH (CHUNK_WIDTH),
    .NUM_CHUNKS  (NUM_CHUNKS)
  ) u_buf (
    .i_clk      (i_clk),
    .i_resetn   (i_resetn),
    .i_we       (buf_we),
    .i_addr     (bus.i_addr),
    .i_data     (bus.i_data_in),
    .i_mask_clr (mask_clr),
    .o_written  (written),
    .i_rd_idx   (rd_idx),
    .o_rd_chunk (rd_chunk)
  );

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      state     <= FILL;
      inready_q <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
      chunk_q   <= '0;
      idx_q     <= 5'd0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (bus.i_clear) begin
        // Clear wins over everything and aborts a stream without o_done.
        state     <= FILL;
        inready_q <= 1'b1;
        count_q   <= '0;
        err_q     <= 1'b0;
        valid_q   <= 1'b0;
      end else begin
        case (state)
          FILL: begin
            inready_q <= 1'b1;
            if (bus.i_we) begin
              // A write takes priority over i_go; the host reissues i_go.
              if (!addr_ok) begin
                err_q <= 1'b1;
              end else if (!written) begin
                count_q <= count_q + 1'b1;
              end
            end else if (bus.i_go) begin
              if (full) begin
                state     <= SEND;
                inready_q <= 1'b0;
                chunk_q   <= rd_chunk;
                idx_q     <= 5'd0;
                valid_q   <= 1'b1;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          SEND: begin
            inready_q <= 1'b0;
            if (bus.i_we) begin
              err_q <= 1'b1;
            end
            if (accept) begin
              if (idx_q == LAST_IDX) begin
                state     <= FILL;
                inready_q <= 1'b1;
                valid_q   <= 1'b0;
                done_q    <= 1'b1;
                count_q   <= '0;
              end else begin
                idx_q   <= idx_q + 5'd1;
                chunk_q <= rd_chunk;
              end
            end
          end
          default: begin
            state <= FILL;
          end
        endcase
      end
    end
  end

  assign bus.o_inready     = inready_q;
  assign bus.o_count       = count_q;
  assign bus.o_full        = full;
  assign bus.o_chunk_data  = chunk_q;
  assign bus.o_chunk_idx   = idx_q;
  assign bus.o_chunk_valid = valid_q;
  assign bus.o_done        = done_q;
  assign bus.o_err         = err_q;

endmodule

// File: tb/tb_ct_assembler.sv
// tb/tb_ct_assembler.sv - self-checking bench for ct_assembler

module tb_ct_assembler;

  logic clk;
  logic resetn;

  ct_assembler_if bus ();

  ct_assembler dut (
    .i_clk    (clk),
    .i_resetn (resetn),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: word memory, written-set and stream position.
  logic [31:0] m_mem [192];
  bit          m_written [192];
  bit          m_rst = 1'b1;
  bit          m_sending = 1'b0;
  int          m_idx = 0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  bit          started = 1'b0;

  int          got_idx [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int a = 0; a < 192; a++) n += m_written[a] ? 1 : 0;
    return n;
  endfunction

  function automatic logic [255:0] m_chunk(input int c);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[255-32*k -: 32] = m_mem[c*8+k];
    return r;
  endfunction

  function automatic void m_forget();
    for (int a = 0; a < 192; a++) m_written[a] = 1'b0;
  endfunction

  initial begin
    for (int a = 0; a < 192; a++) begin
      m_mem[a] = '0;
      m_written[a] = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      m_rst = 1'b1; m_sending = 1'b0; m_idx = 0; m_done = 1'b0; m_err = 1'b0;
      m_forget();
    end else begin
      m_rst = 1'b0;
      m_done = 1'b0;
      if (bus.i_clear) begin
        m_forget();
        m_err = 1'b0;
        m_sending = 1'b0;
      end else if (!m_sending) begin
        if (bus.i_we) begin
          if (int'(bus.i_addr) < 192) begin
            m_mem[bus.i_addr] = bus.i_data_in;
            m_written[bus.i_addr] = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end else if (bus.i_go) begin
          if (m_count() == 192) begin
            m_sending = 1'b1;
            m_idx = 0;
          end else begin
            m_err = 1'b1;
          end
        end
      end else begin
        if (bus.i_we) m_err = 1'b1;
        if (bus.i_chunk_ready) begin
          if (m_idx == 23) begin
            m_sending = 1'b0;
            m_done = 1'b1;
            m_forget();
          end else begin
            m_idx++;
          end
        end
      end
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      int c;
      c = m_rst ? 0 : m_count();
      check("inready", bus.o_inready, !m_rst && !m_sending);
      check("count", bus.o_count, c);
      check("full", bus.o_full, c == 192);
      check("valid", bus.o_chunk_valid, m_sending);
      check("done", bus.o_done, m_done);
      check("err", bus.o_err, m_err);
      if (m_rst) begin
        check("rst_idx", bus.o_chunk_idx, 0);
        check("rst_data", bus.o_chunk_data, 0);
      end else if (m_sending) begin
        check("idx", bus.o_chunk_idx, m_idx);
        check("data", bus.o_chunk_data, m_chunk(m_idx));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    bus.i_we = 1'b1;
    bus.i_addr = 8'(a);
    bus.i_data_in = d;
    cyc();
    bus.i_we = 1'b0;
  endtask

  task automatic pulse_go();
    bus.i_go = 1'b1;
    cyc();
    bus.i_go = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.i_clear = 1'b1;
    cyc();
    bus.i_clear = 1'b0;
  endtask

  task automatic fill_random(input int skip);
    for (int a = 0; a < 192; a++)
      if (a != skip) write_word(a, $urandom);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0,1, 2: random ready.
  // clear_at >= 0 aborts the stream with i_clear when that index is shown.
  task automatic drain(input int mode, input int clear_at, output int cycles);
    bit r;
    bit aborted;
    int n;
    n = 0;
    aborted = 1'b0;
    got_idx.delete();
    while (n < 400) begin
      case (mode)
        0: r = 1'b1;
        1: r = (n % 4 == 0) || (n % 4 == 3);
        default: r = 1'($urandom % 2);
      endcase
      bus.i_chunk_ready = r;
      if (clear_at >= 0 && bus.o_chunk_valid && int'(bus.o_chunk_idx) == clear_at) begin
        bus.i_clear = 1'b1;
        aborted = 1'b1;
      end else if (bus.o_chunk_valid && r) begin
        got_idx.push_back(int'(bus.o_chunk_idx));
      end
      cyc();
      n++;
      if (aborted) begin
        bus.i_clear = 1'b0;
        break;
      end
      if (bus.o_done) break;
    end
    bus.i_chunk_ready = 1'b0;
    cycles = n;
    if (n >= 400) check("drain_timeout", 1'b1, 1'b0);
  endtask

  task automatic check_seq(input string name);
    check({name, "_n"}, got_idx.size(), 24);
    for (int i = 0; i < got_idx.size() && i < 24; i++)
      check({name, "_idx"}, got_idx[i], i);
  endtask

  initial begin
    logic [255:0] exp0;
    logic [31:0]  f5;
    int cycles;

    bus.i_we = 1'b0; bus.i_addr = '0; bus.i_data_in = '0;
    bus.i_go = 1'b0; bus.i_clear = 1'b0; bus.i_chunk_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) cyc();
    check("reset_inready", bus.o_inready, 0);
    check("reset_err", bus.o_err, 0);
    resetn = 1'b1;
    cyc();
    check("post_reset_inready", bus.o_inready, 1);
    check("post_reset_count", bus.o_count, 0);

    // Full ciphertext with a recognisable pattern, ready held high.
    for (int a = 0; a < 192; a++) write_word(a, 32'hA500_0000 + 32'(a));
    check("t1_count", bus.o_count, 192);
    check("t1_full", bus.o_full, 1);
    pulse_go();
    exp0 = {32'hA500_0000, 32'hA500_0001, 32'hA500_0002, 32'hA500_0003,
            32'hA500_0004, 32'hA500_0005, 32'hA500_0006, 32'hA500_0007};
    check("t1_valid", bus.o_chunk_valid, 1);
    check("t1_idx0", bus.o_chunk_idx, 0);
    check("t1_chunk0", bus.o_chunk_data, exp0);
    check("t1_inready", bus.o_inready, 0);
    drain(0, -1, cycles);
    check("t1_cycles", cycles, 24);
    check_seq("t1");
    check("t1_done", bus.o_done, 1);
    check("t1_count_after", bus.o_count, 0);
    cyc();
    check("t1_done_one_cycle", bus.o_done, 0);

    // One word short: i_go refused with an error, then i_clear recovers.
    for (int a = 0; a < 191; a++) write_word(a, $urandom);
    check("t2_count", bus.o_count, 191);
    pulse_go();
    check("t2_no_valid", bus.o_chunk_valid, 0);
    check("t2_err", bus.o_err, 1);
    pulse_clear();
    check("t2_err_cleared", bus.o_err, 0);
    check("t2_count_cleared", bus.o_count, 0);

    // Overwrites count once; last value wins. Ready pattern 1,0,0,1.
    write_word(5, $urandom);
    write_word(5, $urandom);
    write_word(5, 32'hDEAD_BEEF);
    check("t3_count", bus.o_count, 1);
    fill_random(5);
    pulse_go();
    f5 = bus.o_chunk_data[95:64];
    check("t3_field5", f5, 32'hDEAD_BEEF);
    drain(1, -1, cycles);
    check_seq("t3");

    // Out-of-range write, then a write while streaming.
    write_word(0, $urandom);
    write_word(1, $urandom);
    write_word(200, 32'h1234_5678);
    check("t4_err", bus.o_err, 1);
    check("t4_count", bus.o_count, 2);
    pulse_clear();
    fill_random(-1);
    pulse_go();
    write_word(3, 32'hFFFF_FFFF);
    check("t4_send_err", bus.o_err, 1);
    drain(2, -1, cycles);
    check_seq("t4");

    // Abort with i_clear at chunk 10.
    fill_random(-1);
    pulse_go();
    drain(0, 10, cycles);
    check("t5_valid_low", bus.o_chunk_valid, 0);
    check("t5_no_done", bus.o_done, 0);
    check("t5_inready", bus.o_inready, 1);
    check("t5_count", bus.o_count, 0);
    cyc();

    // Reset in the middle of a stream.
    fill_random(-1);
    pulse_go();
    bus.i_chunk_ready = 1'b1;
    repeat (3) cyc();
    resetn = 1'b0;
    cyc();
    bus.i_chunk_ready = 1'b0;
    check("t6_valid", bus.o_chunk_valid, 0);
    check("t6_inready", bus.o_inready, 0);
    check("t6_data", bus.o_chunk_data, 0);
    check("t6_idx", bus.o_chunk_idx, 0);
    check("t6_done", bus.o_done, 0);
    resetn = 1'b1;
    cyc();
    check("t6_inready_after", bus.o_inready, 1);

    // Random traffic from a full buffer, checked by the model every cycle.
    fill_random(-1);
    for (int i = 0; i < 4000; i++) begin
      bus.i_we = ($urandom % 10) < 6;
      bus.i_addr = ($urandom % 40 == 0) ? 8'(192 + $urandom % 64) : 8'($urandom % 192);
      bus.i_data_in = $urandom;
      bus.i_go = ($urandom % 12) == 0;
      bus.i_clear = ($urandom % 1500) == 0;
      bus.i_chunk_ready = 1'($urandom % 2);
      cyc();
    end
    bus.i_we = 1'b0; bus.i_go = 1'b0; bus.i_clear = 1'b0; bus.i_chunk_ready = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
